bufgce_ce_ctrl: RTL and testbench
=================================

Name: bufgce_ce_ctrl

Overview:
- Clock-enable sequencer driving the CE pin of a BUFGCE (CE_TYPE "SYNC") from logic clocked by the same free-running clock that feeds the buffer's I input.
- Turns a level enable request into a glitch-safe CE waveform with minimum on and off dwell times and a settle interval.
- Returns a four-phase acknowledge once the gated clock has actually started or stopped.
- Sits beside each gated BUFGCE in clock-management wrappers and formal-equivalence test designs.

Parameters:
- INIT_ON, 1, state after reset: 1 means gated clock running (ON), 0 means stopped (OFF); matches the primitive's GSR-enabled default when 1.
- IS_CE_INVERTED, 1'b0, must equal the IS_CE_INVERTED setting on the driven BUFGCE; CE output is pre-inverted so logical enable is preserved.
- MIN_ON_CYCLES, 4, minimum cycles spent in ON (≥1).
- MIN_OFF_CYCLES, 4, minimum cycles spent in OFF (≥1).
- SETTLE_CYCLES, 2, cycles between a CE change and ACK update (≥1); 2 covers SYNC CE latency.
- CNT_W, 32, width of the optional on-cycle counter.

Ports:
- CLK, input, 1, free-running clock; same net as the BUFGCE I input.
- RST_N, input, 1, synchronous active-low reset.
- EN_REQ, input, 1, requested gated-clock state (level).
- EN_ACK, output, 1, confirmed gated-clock state; equals EN_REQ once the transition completes.
- BUSY, output, 1, high in TURN_ON and TURN_OFF.
- CE, output, 1, to BUFGCE CE; equals ce_int ^ IS_CE_INVERTED.

Behaviour:
- All outputs are registered; no combinational path from EN_REQ to any output.
- States: OFF, TURN_ON, ON, TURN_OFF. A dwell counter is cleared on entry to every state and saturates at max(MIN_ON_CYCLES, MIN_OFF_CYCLES, SETTLE_CYCLES).
- Reset (RST_N=0 at a CLK edge):
  - INIT_ON=1: state ON, ce_int=1, EN_ACK=1.
  - INIT_ON=0: state OFF, ce_int=0, EN_ACK=0.
  - In both cases BUSY=0 and dwell=0.
  - Reset overrides everything, including a transition in progress. Reset mid-TURN_OFF with INIT_ON=1 returns CE to enable on the next edge.
- OFF: ce_int=0, EN_ACK=0. On an edge with EN_REQ=1 and dwell ≥ MIN_OFF_CYCLES-1, go to TURN_ON, set ce_int=1 and BUSY=1. OFF therefore lasts at least MIN_OFF_CYCLES cycles.
- TURN_ON: ce_int=1, EN_ACK=0. On the edge where dwell == SETTLE_CYCLES-1, go to ON, set EN_ACK=1 and BUSY=0. EN_ACK rises exactly SETTLE_CYCLES edges after ce_int rises.
- ON: ce_int=1, EN_ACK=1. On an edge with EN_REQ=0 and dwell ≥ MIN_ON_CYCLES-1, go to TURN_OFF, set ce_int=0 and BUSY=1.
- TURN_OFF: ce_int=0, EN_ACK=1. On the edge where dwell == SETTLE_CYCLES-1, go to OFF, set EN_ACK=0 and BUSY=0.
- EN_REQ is ignored during TURN_ON and TURN_OFF. A transition always completes; the request is re-evaluated in the destination state under that state's dwell rule.
  - A pulse of EN_REQ that starts and ends inside a transition is lost.
  - A request reversal is honoured only after the minimum dwell time.
- If EN_REQ equals EN_ACK in a stable state, no change occurs and the dwell counter keeps saturating.
- CE never changes more than once per MIN_x + SETTLE_CYCLES window, so the primitive's enable latch sees no runt enables.
- Elaboration: any MIN_* or SETTLE_CYCLES value below 1, or CNT_W below 1, is an error ($error in an initial block / generate).

Optional Feature:
- Macro: BUFGCE_CE_CTRL_CNT_EN.
- Defined:
  - Adds input CNT_CLR (1 bit) and output ON_CYCLES (CNT_W bits).
  - ON_CYCLES increments by one on every edge where state is ON, including ON dwell. It does not count during TURN_ON or TURN_OFF.
  - ON_CYCLES saturates at all ones and does not wrap.
  - CNT_CLR=1 clears the count to 0 on the next edge and has priority over increment.
  - Reset clears ON_CYCLES to 0.
- Undefined: ports CNT_CLR and ON_CYCLES are absent, no counter logic is generated, and the rest of the behaviour is identical.

Test Plan:
- Reset, defaults (INIT_ON=1, IS_CE_INVERTED=0): hold RST_N=0 for 3 edges, EN_REQ=1 → after the first reset edge CE=1, EN_ACK=1, BUSY=0, stable.
- Turn-off then turn-on: release reset, wait 4 edges, drop EN_REQ at edge k → CE=0 after edge k, BUSY=1; EN_ACK=0 after edge k+2. Raise EN_REQ immediately → CE stays 0 until 4 OFF cycles have elapsed, then CE=1; EN_ACK=1 exactly 2 edges later.
- Short request pulse: in ON with dwell satisfied, EN_REQ=0 for 1 cycle → full transition to OFF still completes, then ON is re-entered after the MIN_OFF and SETTLE intervals. Check CE low for exactly 4+2 cycles (MIN_OFF_CYCLES + SETTLE_CYCLES).
- Inversion: IS_CE_INVERTED=1, INIT_ON=0 → CE=1 out of reset; after a request, CE=0 while EN_ACK rises after 2 edges.
- Reset mid-operation: assert RST_N=0 during TURN_OFF (after CE has fallen) → on the next edge CE=1, EN_ACK=1, BUSY=0.
- With BUFGCE_CE_CTRL_CNT_EN: run 10 ON cycles → ON_CYCLES=10. Pulse CNT_CLR → 0. With CNT_W=3, hold ON for 20 cycles → ON_CYCLES=7 and held.

Source files
------------

// File: rtl/bufgce_ce_ctrl.sv
// bufgce_ce_ctrl: sequences the CE pin of a BUFGCE (CE_TYPE "SYNC") so the
// gated clock turns on/off with minimum dwell times and a settle interval,
// and returns a four-phase acknowledge once the gated clock has really
// started or stopped.
// Optional macro BUFGCE_CE_CTRL_CNT_EN adds a saturating ON-cycle counter
// (CNT_CLR input, ON_CYCLES output).
module bufgce_ce_ctrl #(
  parameter int   INIT_ON        = 1,
  parameter logic IS_CE_INVERTED = 1'b0,
  parameter int   MIN_ON_CYCLES  = 4,
  parameter int   MIN_OFF_CYCLES = 4,
  parameter int   SETTLE_CYCLES  = 2,
  parameter int   CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN_REQ,
`ifdef BUFGCE_CE_CTRL_CNT_EN
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] ON_CYCLES,
`endif
  output logic             EN_ACK,
  output logic             BUSY,
  output logic             CE
);

  // Dwell counter only needs to reach the largest threshold, then saturates.
  localparam int DWELL_MAX_A = (MIN_ON_CYCLES > MIN_OFF_CYCLES) ? MIN_ON_CYCLES : MIN_OFF_CYCLES;
  localparam int DWELL_MAX   = (DWELL_MAX_A > SETTLE_CYCLES) ? DWELL_MAX_A : SETTLE_CYCLES;
  localparam int DW          = (DWELL_MAX < 1) ? 1 : $clog2(DWELL_MAX + 1);

  localparam logic [DW-1:0] DWELL_SAT  = DW'(DWELL_MAX);
  localparam logic [DW-1:0] ON_LAST    = DW'(MIN_ON_CYCLES - 1);
  localparam logic [DW-1:0] OFF_LAST   = DW'(MIN_OFF_CYCLES - 1);
  localparam logic [DW-1:0] SETTLE_END = DW'(SETTLE_CYCLES - 1);
  localparam logic          INIT_BIT   = (INIT_ON != 0);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_TURN_ON  = 2'd1,
    ST_ON       = 2'd2,
    ST_TURN_OFF = 2'd3
  } state_t;

  // Bad parameterisation is caught at elaboration rather than in silicon.
  generate
    if (MIN_ON_CYCLES < 1) begin : g_bad_min_on
      $error("bufgce_ce_ctrl: MIN_ON_CYCLES must be >= 1");
    end
    if (MIN_OFF_CYCLES < 1) begin : g_bad_min_off
      $error("bufgce_ce_ctrl: MIN_OFF_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("bufgce_ce_ctrl: SETTLE_CYCLES must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("bufgce_ce_ctrl: CNT_W must be >= 1");
    end
  endgenerate

  state_t        r_state;
  logic [DW-1:0] r_dwell;
  logic          r_ce_int;
  logic          r_ack;
  logic          r_busy;

  // Sequencer: EN_REQ is only looked at in stable states once their dwell is met;
  // transitions always run to completion, and every state entry clears dwell.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= INIT_BIT ? ST_ON : ST_OFF;
      r_ce_int <= INIT_BIT;
      r_ack    <= INIT_BIT;
      r_busy   <= 1'b0;
      r_dwell  <= '0;
    end else begin
      r_dwell <= (r_dwell == DWELL_SAT) ? r_dwell : r_dwell + 1'b1;
      case (r_state)
        ST_OFF: begin
          if (EN_REQ && (r_dwell >= OFF_LAST)) begin
            r_state  <= ST_TURN_ON;
            r_ce_int <= 1'b1;
            r_busy   <= 1'b1;
            r_dwell  <= '0;
          end
        end
        ST_TURN_ON: begin
          if (r_dwell == SETTLE_END) begin
            r_state <= ST_ON;
            r_ack   <= 1'b1;
            r_busy  <= 1'b0;
            r_dwell <= '0;
          end
        end
        ST_ON: begin
          if (!EN_REQ && (r_dwell >= ON_LAST)) begin
            r_state  <= ST_TURN_OFF;
            r_ce_int <= 1'b0;
            r_busy   <= 1'b1;
            r_dwell  <= '0;
          end
        end
        ST_TURN_OFF: begin
          if (r_dwell == SETTLE_END) begin
            r_state <= ST_OFF;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_dwell <= '0;
          end
        end
        default: begin
          r_state  <= ST_OFF;
          r_ce_int <= 1'b0;
          r_ack    <= 1'b0;
          r_busy   <= 1'b0;
          r_dwell  <= '0;
        end
      endcase
    end
  end

  // CE is pre-inverted to cancel the primitive's own CE inversion.
  assign CE     = r_ce_int ^ IS_CE_INVERTED;
  assign EN_ACK = r_ack;
  assign BUSY   = r_busy;

`ifdef BUFGCE_CE_CTRL_CNT_EN
  logic [CNT_W-1:0] r_on_cycles;

  // Counts edges spent in ON (not in transitions); clear wins, saturates at all ones.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_on_cycles <= '0;
    end else if (CNT_CLR) begin
      r_on_cycles <= '0;
    end else if ((r_state == ST_ON) && (r_on_cycles != {CNT_W{1'b1}})) begin
      r_on_cycles <= r_on_cycles + 1'b1;
    end
  end

  assign ON_CYCLES = r_on_cycles;
`endif

endmodule

// File: tb/tb_bufgce_ce_ctrl.sv
// Directed bench for bufgce_ce_ctrl: default instance, inverted-CE instance
// and (with BUFGCE_CE_CTRL_CNT_EN) a 3-bit counter instance, all on one clock.
module tb_bufgce_ce_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance (INIT_ON=1, IS_CE_INVERTED=0)
  logic rst_n, en_req, cnt_clr;
  logic ack, busy, ce;
  // inverted instance (INIT_ON=0, IS_CE_INVERTED=1)
  logic rst_n_i, req_i;
  logic ack_i, busy_i, ce_i;

`ifdef BUFGCE_CE_CTRL_CNT_EN
  logic [31:0] on_cycles;
  logic [2:0]  on_cycles_s;
  logic        ack_s, busy_s, ce_s;
`endif

  bufgce_ce_ctrl u_dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .EN_REQ    (en_req),
`ifdef BUFGCE_CE_CTRL_CNT_EN
    .CNT_CLR   (cnt_clr),
    .ON_CYCLES (on_cycles),
`endif
    .EN_ACK    (ack),
    .BUSY      (busy),
    .CE        (ce)
  );

  bufgce_ce_ctrl #(.INIT_ON(0), .IS_CE_INVERTED(1'b1)) u_inv (
    .CLK       (clk),
    .RST_N     (rst_n_i),
    .EN_REQ    (req_i),
`ifdef BUFGCE_CE_CTRL_CNT_EN
    .CNT_CLR   (1'b0),
    .ON_CYCLES (),
`endif
    .EN_ACK    (ack_i),
    .BUSY      (busy_i),
    .CE        (ce_i)
  );

`ifdef BUFGCE_CE_CTRL_CNT_EN
  bufgce_ce_ctrl #(.CNT_W(3)) u_sat (
    .CLK       (clk),
    .RST_N     (rst_n),
    .EN_REQ    (en_req),
    .CNT_CLR   (cnt_clr),
    .ON_CYCLES (on_cycles_s),
    .EN_ACK    (ack_s),
    .BUSY      (busy_s),
    .CE        (ce_s)
  );
`endif

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic e_ce, input logic e_ack, input logic e_busy);
    check({tag, ".ce"},   {31'd0, ce},   {31'd0, e_ce});
    check({tag, ".ack"},  {31'd0, ack},  {31'd0, e_ack});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    $display("step %s: ce=%0b ack=%0b busy=%0b", tag, ce, ack, busy);
  endtask

  initial begin
    int lows;
    rst_n   = 1'b0;
    en_req  = 1'b1;
    cnt_clr = 1'b0;
    rst_n_i = 1'b0;
    req_i   = 1'b0;

    // reset: ON out of reset and stable
    tick(1); check_st("rst1", 1'b1, 1'b1, 1'b0);
    tick(1); check_st("rst2", 1'b1, 1'b1, 1'b0);
    tick(1); check_st("rst3", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick(4); check_st("on_idle", 1'b1, 1'b1, 1'b0);

    // turn-off then immediate re-request
    en_req = 1'b0;
    tick(1); check_st("off_k", 1'b0, 1'b1, 1'b1);
    en_req = 1'b1;
    tick(1); check_st("off_k1", 1'b0, 1'b1, 1'b1);
    tick(1); check_st("off_k2", 1'b0, 1'b0, 1'b0);
    tick(1); check_st("off_k3", 1'b0, 1'b0, 1'b0);
    tick(2); check_st("off_k5", 1'b0, 1'b0, 1'b0);
    tick(1); check_st("on_k6", 1'b1, 1'b0, 1'b1);
    tick(1); check_st("on_k7", 1'b1, 1'b0, 1'b1);
    tick(1); check_st("on_k8", 1'b1, 1'b1, 1'b0);

    // short pulse: CE low for exactly MIN_OFF + SETTLE edges
    tick(4);
    en_req = 1'b0;
    tick(1);
    en_req = 1'b1;
    lows = (ce === 1'b0) ? 1 : 0;
    for (int i = 0; i < 19; i++) begin
      tick(1);
      if (ce === 1'b0) lows++;
    end
    check("pulse.ce_low_cycles", lows, 32'd6);
    $display("step pulse: ce low for %0d cycles", lows);
    check_st("pulse_end", 1'b1, 1'b1, 1'b0);

    // reset during TURN_OFF
    en_req = 1'b0;
    tick(1); check_st("mid_turnoff", 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    tick(1); check_st("mid_rst", 1'b1, 1'b1, 1'b0);
    en_req = 1'b1;
    rst_n  = 1'b1;

    // inverted CE, starts OFF
    tick(1);
    check("inv.rst.ce", {31'd0, ce_i}, 32'd1);
    check("inv.rst.ack", {31'd0, ack_i}, 32'd0);
    rst_n_i = 1'b1;
    req_i   = 1'b1;
    tick(3);
    check("inv.dwell.ce", {31'd0, ce_i}, 32'd1);
    tick(1);
    check("inv.on.ce", {31'd0, ce_i}, 32'd0);
    check("inv.on.busy", {31'd0, busy_i}, 32'd1);
    check("inv.on.ack1", {31'd0, ack_i}, 32'd0);
    tick(1);
    check("inv.on.ack2", {31'd0, ack_i}, 32'd0);
    tick(1);
    check("inv.on.ack3", {31'd0, ack_i}, 32'd1);
    check("inv.on.busy3", {31'd0, busy_i}, 32'd0);
    $display("step inv: ce=%0b ack=%0b busy=%0b", ce_i, ack_i, busy_i);

`ifdef BUFGCE_CE_CTRL_CNT_EN
    // on-cycle counter: count, saturate (3-bit), clear
    rst_n = 1'b0;
    tick(2);
    check("cnt.rst", on_cycles, 32'd0);
    rst_n = 1'b1;
    tick(10);
    check("cnt.10", on_cycles, 32'd10);
    $display("step cnt: on_cycles=%0d", on_cycles);
    tick(10);
    check("cnt.20", on_cycles, 32'd20);
    check("sat.20", {29'd0, on_cycles_s}, 32'd7);
    tick(3);
    check("sat.held", {29'd0, on_cycles_s}, 32'd7);
    cnt_clr = 1'b1;
    tick(1);
    check("cnt.clr", on_cycles, 32'd0);
    check("sat.clr", {29'd0, on_cycles_s}, 32'd0);
    cnt_clr = 1'b0;
    tick(1);
    check("cnt.after_clr", on_cycles, 32'd1);
    $display("step clr: on_cycles=%0d sat=%0d", on_cycles, on_cycles_s);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
